// File: rtl/pipe_divider.sv
// Multi-cycle restoring integer divider for the RV64 EX stage with valid/ready handshakes,
// RV64M word ops, RISC-V special-case results and flush. Optional early-out: DIVIDER_EARLY_OUT_EN.
module pipe_divider #(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            div_signed,
  input  logic            word_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_X    = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_W    = CW'(WLEN - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W    = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
  localparam logic [1:0]      KIND_DIV0  = 2'd0;
  localparam logic [1:0]      KIND_OVF   = 2'd1;
  localparam logic [1:0]      KIND_EARLY = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPECIAL = 2'd1,
    CALC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    negate = ~x + ONE_X;
  endfunction

  // Results of word ops are always sign-extended from bit WLEN-1.
  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] x, input logic w);
    if (w) word_ext = {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]};
    else   word_ext = x;
  endfunction

  function automatic logic [XLEN-1:0] op_ext(input logic [XLEN-1:0] x, input logic w,
                                             input logic s);
    if (w && s)  op_ext = {{(XLEN-WLEN){x[WLEN-1]}}, x[WLEN-1:0]};
    else if (w)  op_ext = {{(XLEN-WLEN){1'b0}}, x[WLEN-1:0]};
    else         op_ext = x;
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic s);
    if (s && x[XLEN-1]) magnitude = negate(x);
    else                magnitude = x;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [XLEN-1:0] a_r, b_r, quo_r, rem_r, dmag_r;
  logic [XLEN-1:0] quotient_r, remainder_r;
  logic            signed_r, word_r, prep_r, neg_q_r, neg_r_r, out_valid_r;
  logic [1:0]      kind_r;
  logic [CW-1:0]   count_r;

  logic [XLEN-1:0] a_ext_s, b_ext_s, quo_nxt_s, rem_nxt_s;
  logic [XLEN-1:0] q_fix_s, r_fix_s, q_spec_s, r_spec_s, amag_s;
  logic [XLEN:0]   shifted_s, diff_s;
  logic            zero_s, ovf_s, early_s, accept_s, ge_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

  assign accept_s = in_valid && (state_r == IDLE) && !flush;
  assign a_ext_s  = op_ext(dividend, word_op, div_signed);
  assign b_ext_s  = op_ext(divisor, word_op, div_signed);
  assign zero_s   = (b_ext_s == ZERO_X);
  assign ovf_s    = div_signed && (b_ext_s == ONES_X) &&
                    (a_ext_s == (word_op ? MIN_W : MIN_X));

`ifdef DIVIDER_EARLY_OUT_EN
  assign early_s = !zero_s &&
                   (magnitude(a_ext_s, div_signed) < magnitude(b_ext_s, div_signed));
`else
  assign early_s = 1'b0;
`endif

  // One restoring step; the remainder stays below the divisor, so diff_s[XLEN] is the borrow.
  assign shifted_s = {rem_r, quo_r[XLEN-1]};
  assign diff_s    = shifted_s - {1'b0, dmag_r};
  assign ge_s      = !diff_s[XLEN];
  assign rem_nxt_s = ge_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
  assign quo_nxt_s = {quo_r[XLEN-2:0], ge_s};
  assign q_fix_s   = word_ext(neg_q_r ? negate(quo_nxt_s) : quo_nxt_s, word_r);
  assign r_fix_s   = word_ext(neg_r_r ? negate(rem_nxt_s) : rem_nxt_s, word_r);
  assign amag_s    = magnitude(a_r, signed_r);

  // Special-case result selection.
  always_comb begin
    q_spec_s = ZERO_X;
    r_spec_s = ZERO_X;
    case (kind_r)
      KIND_DIV0: begin
        q_spec_s = ONES_X;
        r_spec_s = word_ext(a_r, word_r);
      end
      KIND_OVF: begin
        q_spec_s = word_ext(a_r, word_r);
        r_spec_s = ZERO_X;
      end
      KIND_EARLY: begin
        q_spec_s = ZERO_X;
        r_spec_s = word_ext(a_r, word_r);
      end
      default: begin
        q_spec_s = ZERO_X;
        r_spec_s = ZERO_X;
      end
    endcase
  end

  // Next-state logic; flush wins over every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) state_nxt_s = (zero_s || ovf_s || early_s) ? SPECIAL : CALC;
          else          state_nxt_s = IDLE;
        end
        SPECIAL: begin
          if (!prep_r) state_nxt_s = DONE;
          else         state_nxt_s = SPECIAL;
        end
        CALC: begin
          if (!prep_r && (count_r == CNT_ZERO)) state_nxt_s = DONE;
          else                                  state_nxt_s = CALC;
        end
        DONE: begin
          if (out_ready) state_nxt_s = IDLE;
          else           state_nxt_s = DONE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Operand capture; the cycle after accept conditions operands into magnitudes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      a_r      <= ZERO_X;
      b_r      <= ZERO_X;
      signed_r <= 1'b0;
      word_r   <= 1'b0;
      kind_r   <= KIND_DIV0;
      prep_r   <= 1'b0;
    end else begin
      prep_r <= accept_s;
      if (accept_s) begin
        a_r      <= a_ext_s;
        b_r      <= b_ext_s;
        signed_r <= div_signed;
        word_r   <= word_op;
        kind_r   <= zero_s ? KIND_DIV0 : (ovf_s ? KIND_OVF : KIND_EARLY);
      end
    end
  end

  // Shift-subtract datapath and iteration counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      quo_r   <= ZERO_X;
      rem_r   <= ZERO_X;
      dmag_r  <= ZERO_X;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      count_r <= CNT_ZERO;
    end else if ((state_r == CALC) && prep_r) begin
      quo_r   <= word_r ? (amag_s << (XLEN - WLEN)) : amag_s;
      rem_r   <= ZERO_X;
      dmag_r  <= magnitude(b_r, signed_r);
      neg_q_r <= signed_r && (a_r[XLEN-1] ^ b_r[XLEN-1]);
      neg_r_r <= signed_r && a_r[XLEN-1];
      count_r <= word_r ? CNT_W : CNT_X;
    end else if (state_r == CALC) begin
      quo_r <= quo_nxt_s;
      rem_r <= rem_nxt_s;
      if (count_r != CNT_ZERO) count_r <= count_r - CNT_ONE;
    end
  end

  // Result registers, loaded only on entry to DONE and held through backpressure.
  always_ff @(posedge clock) begin
    if (!reset) begin
      quotient_r  <= ZERO_X;
      remainder_r <= ZERO_X;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == DONE);
      if ((state_r == CALC) && (state_nxt_s == DONE)) begin
        quotient_r  <= q_fix_s;
        remainder_r <= r_fix_s;
      end else if ((state_r == SPECIAL) && (state_nxt_s == DONE)) begin
        quotient_r  <= q_spec_s;
        remainder_r <= r_spec_s;
      end
    end
  end

endmodule

// File: tb/tb_pipe_divider.sv
// Scoreboard bench for pipe_divider: driver pushes expected results, monitor pops on handshake.
module tb_pipe_divider;

  localparam int XLEN = 64;
  localparam int WLEN = 32;
`ifdef DIVIDER_EARLY_OUT_EN
  localparam int LAT_SMALL = 2;
`else
  localparam int LAT_SMALL = 65;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            div_signed = 1'b0;
  logic            word_op = 1'b0;
  logic [XLEN-1:0] dividend = 64'd0;
  logic [XLEN-1:0] divisor = 64'd0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  pipe_divider #(.XLEN(XLEN), .WLEN(WLEN)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .div_signed(div_signed), .word_op(word_op),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cycle = 0;
  bit   valid_seen = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: latency on first valid, values on the out_valid/out_ready handshake.
  always @(negedge clock) begin
    if (reset && out_valid) begin
      if (!valid_seen) begin
        valid_seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=%h expected=no result", quotient);
        end else begin
          check64({sb[0].name, "_latency"}, 64'(cyc - acc_cycle), 64'(sb[0].lat));
        end
      end
      if (out_ready) begin
        valid_seen = 1'b0;
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check64({e.name, "_q"}, quotient, e.q);
          check64({e.name, "_r"}, remainder, e.r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input string name, input bit s, input bit w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er,
                       input int lat);
    int n = 0;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_ready_timeout actual=0 expected=1", name);
    end else begin
      sb.push_back('{name: name, q: eq, r: er, lat: lat});
      div_signed = s;
      word_op    = w;
      dividend   = a;
      divisor    = b;
      in_valid   = 1'b1;
      step();
      acc_cycle  = cyc;
      in_valid   = 1'b0;
      dividend   = 64'hDEAD_BEEF_0BAD_F00D;
      divisor    = 64'h0000_0000_0000_0000;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    int busy_ready = 0;
    while (sb.size() != 0 && n < 300) begin
      if (!out_valid && in_ready) busy_ready++;
      step();
      n++;
    end
    check64({name, "_drained"}, 64'(sb.size()), 64'd0);
    check64({name, "_busy_in_ready"}, 64'(busy_ready), 64'd0);
  endtask

  initial begin
    int n;
    int bad;
    repeat (3) step();
    check64("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check64("reset_quotient", quotient, 64'd0);
    check64("reset_remainder", remainder, 64'd0);
    check64("reset_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b1;
    step();

    issue("sdiv_pos", 1'b1, 1'b0, 64'd1165, 64'd7, 64'd166, 64'd3, 65);
    drain("sdiv_pos");
    issue("sdiv_neg", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FB73, 64'd7,
          64'hFFFF_FFFF_FFFF_FF5A, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    drain("sdiv_neg");
    issue("sdiv_negdiv", 1'b1, 1'b0, 64'd1165, 64'hFFFF_FFFF_FFFF_FFF9,
          64'hFFFF_FFFF_FFFF_FF5A, 64'd3, 65);
    drain("sdiv_negdiv");
    issue("udiv_zero", 1'b0, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 2);
    drain("udiv_zero");
    issue("sdiv_ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 64'd0, 2);
    drain("sdiv_ovf");
    issue("divw_ovf", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFF_8000_0000, 64'd0, 2);
    drain("divw_ovf");
    issue("divuw_one", 1'b0, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 33);
    drain("divuw_one");
    issue("divw_neg", 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h7777_0000_0000_0002,
          64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    drain("divw_neg");
    issue("divw_zero", 1'b1, 1'b1, 64'hDEAD_BEEF_8000_0001, 64'hABCD_0000_0000_0000,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 2);
    drain("divw_zero");
    issue("udiv_big", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000,
          64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 65);
    drain("udiv_big");
    issue("udiv_small", 1'b0, 1'b0, 64'd3, 64'd7, 64'd0, 64'd3, LAT_SMALL);
    drain("udiv_small");
    issue("sdiv_small", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
          64'd0, 64'hFFFF_FFFF_FFFF_FFFD, LAT_SMALL);
    drain("sdiv_small");

    // Backpressure: hold out_ready low for 10 cycles in DONE.
    out_ready = 1'b0;
    issue("bp", 1'b0, 1'b0, 64'd1165, 64'd7, 64'd166, 64'd3, 65);
    n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
    check64("bp_valid_seen", {63'd0, out_valid}, 64'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || in_ready || quotient !== 64'd166 || remainder !== 64'd3) bad++;
      step();
    end
    check64("bp_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    check64("bp_in_ready_before_hs", {63'd0, in_ready}, 64'd0);
    step();
    check64("bp_in_ready_after_hs", {63'd0, in_ready}, 64'd1);
    check64("bp_valid_after_hs", {63'd0, out_valid}, 64'd0);
    drain("bp");

    // Flush at iteration 20.
    issue("fl", 1'b0, 1'b0, 64'd1165, 64'd7, 64'd166, 64'd3, 65);
    repeat (21) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    void'(sb.pop_back());
    check64("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check64("flush_out_valid", {63'd0, out_valid}, 64'd0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) bad++;
      step();
    end
    check64("flush_no_valid", 64'(bad), 64'd0);

    // flush together with in_valid in IDLE must not accept.
    in_valid = 1'b1;
    flush    = 1'b1;
    dividend = 64'd5;
    divisor  = 64'd1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    check64("flush_accept_blocked", {63'd0, in_ready}, 64'd1);
    issue("after_flush", 1'b0, 1'b0, 64'd1000, 64'd10, 64'd100, 64'd0, 65);
    drain("after_flush");

    // Reset in the middle of CALC.
    issue("rst", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FB73, 64'd7, 64'd0, 64'd0, 65);
    repeat (10) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    void'(sb.pop_back());
    check64("rst_quotient", quotient, 64'd0);
    check64("rst_remainder", remainder, 64'd0);
    check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check64("rst_in_ready", {63'd0, in_ready}, 64'd1);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) bad++;
      step();
    end
    check64("rst_no_valid", 64'(bad), 64'd0);
    issue("after_rst", 1'b1, 1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF6,
          64'hFFFF_FFFF_FFFF_FF9C, 64'd0, 65);
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
